// File: rtl/uart_pkg.sv
// uart_pkg: shared parity encodings, FSM state type and parity helper for the UART transceiver
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_t;
  function automatic logic calc_parity(input logic [7:0] data, input int nbits, input int mode);
    logic x;
    x = 1'b0;
    for (int i = 0; i < 8; i++) if (i < nbits) x = x ^ data[i];
    return (mode == PAR_ODD) ? ~x : x;
  endfunction
endpackage

// File: rtl/uart_fifo_xcvr_if.sv
// uart_fifo_xcvr_if: fabric-side push/pop handshakes, error flags and FIFO occupancy
interface uart_fifo_xcvr_if #(parameter int CW = 5);
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic rx_frame_err;
  logic rx_parity_err;
  logic rx_overrun;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;
  modport master (
    output tx_data, tx_valid, rx_ready,
    input tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun, tx_count, rx_count
  );
  modport slave (
    input tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun, tx_count, rx_count
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; the extra pointer bit separates full from empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic full_o,
  output logic empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, rd_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic do_push, do_pop;
  assign count_o = wr_q - rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o = count_o[AW];
  assign do_pop = pop_i & ~empty_o;
  // a pop in the same cycle frees the slot a full FIFO needs for the push
  assign do_push = push_i & (~full_o | pop_i);
  assign rdata_o = mem[rd_q[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_q[AW-1:0]] <= wdata_i;
endmodule

// File: rtl/uart_fifo_xcvr.sv
// uart_fifo_xcvr: full-duplex UART with FWFT TX/RX FIFOs and per-byte parity/frame error flags
module uart_fifo_xcvr
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 25_000_000,
  parameter int BAUD = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic tx,
  uart_fifo_xcvr_if.slave bus
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CNTW = $clog2(DIV) + 1;
  localparam logic [CNTW-1:0] DIV_M1 = CNTW'(DIV - 1);
  localparam logic [CNTW-1:0] HALF_M1 = CNTW'(DIV / 2 - 1);
  localparam logic [2:0] DB_M1 = 3'(DATA_BITS - 1);
  localparam logic [2:0] SB_M1 = 3'(STOP_BITS - 1);
  localparam uart_state_t AFTER_DATA = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;

  logic [DATA_BITS-1:0] tx_head;
  logic tx_full, tx_empty, tx_pop;
  uart_state_t ts_q, ts_d;
  logic [CNTW-1:0] tcnt_q, tcnt_d;
  logic [2:0] tbit_q, tbit_d;
  logic [DATA_BITS-1:0] tsh_q, tsh_d;
  logic tpar_q, tpar_d, tx_q, tx_d, tdone, tload;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push_i(bus.tx_valid), .wdata_i(bus.tx_data[DATA_BITS-1:0]),
    .pop_i(tx_pop), .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(bus.tx_count)
  );

  always_comb begin
    tdone = tcnt_q == DIV_M1;
    tload = !tx_empty && (ts_q == ST_IDLE || (ts_q == ST_STOP && tdone && tbit_q == SB_M1));
    tx_pop = tload;
    ts_d = ts_q;
    tbit_d = tbit_q;
    tsh_d = tsh_q;
    tpar_d = tpar_q;
    tcnt_d = (ts_q == ST_IDLE || tdone) ? '0 : tcnt_q + 1'b1;
    case (ts_q)
      ST_START: if (tdone) begin ts_d = ST_DATA; tbit_d = '0; end
      ST_DATA: if (tdone) begin
        tsh_d = tsh_q >> 1;
        tbit_d = (tbit_q == DB_M1) ? '0 : tbit_q + 1'b1;
        ts_d = (tbit_q == DB_M1) ? AFTER_DATA : ST_DATA;
      end
      ST_PARITY: if (tdone) begin ts_d = ST_STOP; tbit_d = '0; end
      ST_STOP: if (tdone) begin
        tbit_d = tbit_q + 1'b1;
        ts_d = (tbit_q == SB_M1) ? ST_IDLE : ST_STOP;
      end
      default: ;
    endcase
    // a queued byte takes over straight from the last stop bit, so frames run back-to-back
    if (tload) begin
      ts_d = ST_START;
      tcnt_d = '0;
      tsh_d = tx_head;
      tpar_d = calc_parity(8'(tx_head), DATA_BITS, PARITY);
    end
    tx_d = (ts_d == ST_START) ? 1'b0 : (ts_d == ST_DATA) ? tsh_d[0] : (ts_d == ST_PARITY) ? tpar_d : 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ts_q <= ST_IDLE;
      tcnt_q <= '0;
      tbit_q <= '0;
      tsh_q <= '0;
      tpar_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      ts_q <= ts_d;
      tcnt_q <= tcnt_d;
      tbit_q <= tbit_d;
      tsh_q <= tsh_d;
      tpar_q <= tpar_d;
      tx_q <= tx_d;
    end

  assign tx = tx_q;
  assign bus.tx_ready = ~tx_full;

  logic [1:0] sync_q;
  logic rxs, rsamp, rx_push, rx_full, rx_empty;
  uart_state_t rs_q, rs_d;
  logic [CNTW-1:0] rcnt_q, rcnt_d;
  logic [2:0] rbit_q, rbit_d;
  logic [DATA_BITS-1:0] rsh_q, rsh_d;
  logic ferr_q, ferr_d, perr_q, perr_d, brk_q, brk_d, ov_q;
  logic [DATA_BITS+1:0] rx_wdata, rx_head;

  assign rxs = sync_q[1];

  always_comb begin
    rsamp = rcnt_q == ((rs_q == ST_START) ? HALF_M1 : DIV_M1);
    rs_d = rs_q;
    rbit_d = rbit_q;
    rsh_d = rsh_q;
    ferr_d = ferr_q;
    perr_d = perr_q;
    brk_d = brk_q;
    rx_push = 1'b0;
    rcnt_d = (rs_q == ST_IDLE || rsamp) ? '0 : rcnt_q + 1'b1;
    rx_wdata = {rsh_q, ferr_q | ~rxs, perr_q};
    case (rs_q)
      // after a frame error the line must go high again before a new start is believed
      ST_IDLE: begin
        brk_d = brk_q & ~rxs;
        if (!brk_q && !rxs) rs_d = ST_START;
      end
      ST_START: if (rsamp) begin
        rs_d = rxs ? ST_IDLE : ST_DATA;
        rbit_d = '0;
        ferr_d = 1'b0;
        perr_d = 1'b0;
      end
      ST_DATA: if (rsamp) begin
        rsh_d = {rxs, rsh_q[DATA_BITS-1:1]};
        rbit_d = (rbit_q == DB_M1) ? '0 : rbit_q + 1'b1;
        rs_d = (rbit_q == DB_M1) ? AFTER_DATA : ST_DATA;
      end
      ST_PARITY: if (rsamp) begin
        perr_d = rxs ^ calc_parity(8'(rsh_q), DATA_BITS, PARITY);
        rs_d = ST_STOP;
        rbit_d = '0;
      end
      ST_STOP: if (rsamp) begin
        ferr_d = ferr_q | ~rxs;
        rbit_d = rbit_q + 1'b1;
        if (rbit_q == SB_M1) begin
          rx_push = 1'b1;
          rs_d = ST_IDLE;
          brk_d = ferr_q | ~rxs;
        end
      end
      default: rs_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= 2'b11;
      rs_q <= ST_IDLE;
      rcnt_q <= '0;
      rbit_q <= '0;
      rsh_q <= '0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      brk_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx};
      rs_q <= rs_d;
      rcnt_q <= rcnt_d;
      rbit_q <= rbit_d;
      rsh_q <= rsh_d;
      ferr_q <= ferr_d;
      perr_q <= perr_d;
      brk_q <= brk_d;
      ov_q <= rx_push & rx_full & ~bus.rx_ready;
    end

  sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push_i(rx_push), .wdata_i(rx_wdata), .pop_i(bus.rx_ready),
    .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(bus.rx_count)
  );

  assign bus.rx_valid = ~rx_empty;
  assign bus.rx_data = rx_empty ? 8'h00 : 8'(rx_head[DATA_BITS+1:2]);
  assign bus.rx_frame_err = ~rx_empty & rx_head[1];
  assign bus.rx_parity_err = ~rx_empty & rx_head[0];
  assign bus.rx_overrun = ov_q;
endmodule

// File: tb/tb_uart_fifo_xcvr.sv
// tb_uart_fifo_xcvr: directed checks of an 8N1 instance (A) and a 7E1 instance (B), DIV=16
module tb_uart_fifo_xcvr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd_a = 1'b1;
  logic rxd_b = 1'b1;
  logic loop = 1'b0;
  logic tx_a, tx_b, rx_a;
  int checks = 0;
  int errors = 0;
  int ovc = 0;

  always #5 clk = ~clk;
  assign rx_a = loop ? tx_a : rxd_a;

  uart_fifo_xcvr_if #(.CW(5)) bus_a ();
  uart_fifo_xcvr_if #(.CW(5)) bus_b ();

  uart_fifo_xcvr #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16))
    dut_a (.clk(clk), .rst(rst), .rx(rx_a), .tx(tx_a), .bus(bus_a));
  uart_fifo_xcvr #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16))
    dut_b (.clk(clk), .rst(rst), .rx(rxd_b), .tx(tx_b), .bus(bus_b));

  always @(posedge clk) if (bus_a.rx_overrun === 1'b1) ovc <= ovc + 1;

  task automatic drive_bits(input logic [15:0] bits, input int n, input bit to_b);
    for (int i = 0; i < n; i++) begin
      if (to_b) rxd_b = bits[i];
      else rxd_a = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tx_a, bus_a.tx_ready, bus_a.rx_valid, tx_b} !== 4'b1101) begin
      errors++;
      $display("FAIL reset_a_flags: tx,tx_ready,rx_valid,tx_b=%b expected 1101", {tx_a, bus_a.tx_ready, bus_a.rx_valid, tx_b});
    end
    checks++;
    if ({bus_a.rx_data, bus_a.rx_frame_err, bus_a.rx_parity_err, bus_a.rx_overrun} !== 11'h0) begin
      errors++;
      $display("FAIL reset_rx_out: got %h expected 000", {bus_a.rx_data, bus_a.rx_frame_err, bus_a.rx_parity_err, bus_a.rx_overrun});
    end
    checks++;
    if ({bus_a.tx_count, bus_a.rx_count} !== 10'h0) begin
      errors++;
      $display("FAIL reset_counts: tx_count=%0d rx_count=%0d expected 0 0", bus_a.tx_count, bus_a.rx_count);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({tx_a, bus_a.tx_ready, bus_a.rx_valid} !== 3'b110) begin
      errors++;
      $display("FAIL post_reset_idle: got %b expected 110", {tx_a, bus_a.tx_ready, bus_a.rx_valid});
    end
  endtask

  task automatic test_tx_frame;
    logic [9:0] f;
    int bad;
    f = {1'b1, 8'hA5, 1'b0};
    @(posedge clk);
    #1;
    bus_a.tx_data = 8'hA5;
    bus_a.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_a.tx_valid = 1'b0;
    checks++;
    if (tx_a !== 1'b1 || bus_a.tx_count !== 5'd1) begin
      errors++;
      $display("FAIL tx_latency_1: tx=%b count=%0d expected 1 1", tx_a, bus_a.tx_count);
    end
    @(posedge clk);
    #1;
    checks++;
    if (tx_a !== 1'b0 || bus_a.tx_count !== 5'd0) begin
      errors++;
      $display("FAIL tx_latency_2: tx=%b count=%0d expected 0 0", tx_a, bus_a.tx_count);
    end
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < 16; c++) begin
        if (tx_a !== f[b]) bad++;
        @(posedge clk);
        #1;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL tx_a5_bit%0d: %0d of 16 cycles wrong, expected %b", b, bad, f[b]);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (tx_a !== 1'b1) begin
      errors++;
      $display("FAIL tx_idle_after: tx=%b expected 1", tx_a);
    end
  endtask

  task automatic test_loopback;
    logic [7:0] by [3];
    logic [9:0] fb;
    int bad;
    by = '{8'h00, 8'hFF, 8'h3C};
    loop = 1'b1;
    @(posedge clk);
    #1;
    bus_a.tx_data = by[0];
    bus_a.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_a.tx_data = by[1];
    @(posedge clk);
    #1;
    bus_a.tx_data = by[2];
    @(posedge clk);
    #1;
    bus_a.tx_valid = 1'b0;
    bad = 0;
    for (int t = 1; t < 480; t++) begin
      fb = {1'b1, by[t / 160], 1'b0};
      if (tx_a !== fb[(t / 16) % 10]) bad++;
      if (t % 16 == 15) begin
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL loop_tx_bit%0d: %0d cycles wrong, expected %b", t / 16, bad, fb[(t / 16) % 10]);
        end
        bad = 0;
      end
      @(posedge clk);
      #1;
    end
    repeat (24) @(posedge clk);
    #1;
    checks++;
    if (bus_a.rx_count !== 5'd3 || tx_a !== 1'b1) begin
      errors++;
      $display("FAIL loop_rx_count: count=%0d tx=%b expected 3 1", bus_a.rx_count, tx_a);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus_a.rx_valid, bus_a.rx_data, bus_a.rx_frame_err, bus_a.rx_parity_err} !== {1'b1, by[i], 2'b00}) begin
        errors++;
        $display("FAIL loop_pop%0d: valid=%b data=%h ferr=%b perr=%b expected 1 %h 0 0", i,
                 bus_a.rx_valid, bus_a.rx_data, bus_a.rx_frame_err, bus_a.rx_parity_err, by[i]);
      end
      bus_a.rx_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_a.rx_ready = 1'b0;
    end
    checks++;
    if (bus_a.rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL loop_empty: rx_valid=%b expected 0", bus_a.rx_valid);
    end
    loop = 1'b0;
  endtask

  task automatic test_parity;
    logic [9:0] fr [3];
    logic [7:0] dat [3];
    logic perr [3];
    fr = '{{1'b1, 1'b1, 7'h41, 1'b0}, {1'b1, 1'b0, 7'h41, 1'b0}, {1'b1, 1'b1, 7'h43, 1'b0}};
    dat = '{8'h41, 8'h41, 8'h43};
    perr = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive_bits(16'(fr[i]), 10, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if ({bus_b.rx_valid, bus_b.rx_data, bus_b.rx_frame_err, bus_b.rx_parity_err} !== {1'b1, dat[i], 1'b0, perr[i]}) begin
        errors++;
        $display("FAIL parity_frame%0d: valid=%b data=%h ferr=%b perr=%b expected 1 %h 0 %b", i,
                 bus_b.rx_valid, bus_b.rx_data, bus_b.rx_frame_err, bus_b.rx_parity_err, dat[i], perr[i]);
      end
      bus_b.rx_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_b.rx_ready = 1'b0;
    end
  endtask

  task automatic test_frame_err;
    drive_bits(16'({1'b0, 8'h55, 1'b0}), 10, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (bus_a.rx_count !== 5'd1 || {bus_a.rx_data, bus_a.rx_frame_err, bus_a.rx_parity_err} !== {8'h55, 2'b10}) begin
      errors++;
      $display("FAIL ferr_entry: count=%0d data=%h ferr=%b perr=%b expected 1 55 1 0",
               bus_a.rx_count, bus_a.rx_data, bus_a.rx_frame_err, bus_a.rx_parity_err);
    end
    rxd_a = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (bus_a.rx_count !== 5'd1) begin
      errors++;
      $display("FAIL ferr_no_false_start: count=%0d expected 1", bus_a.rx_count);
    end
    drive_bits(16'({1'b1, 8'h12, 1'b0}), 10, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus_a.rx_count !== 5'd2) begin
      errors++;
      $display("FAIL ferr_recover_count: count=%0d expected 2", bus_a.rx_count);
    end
    bus_a.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_a.rx_ready = 1'b0;
    checks++;
    if ({bus_a.rx_data, bus_a.rx_frame_err, bus_a.rx_parity_err} !== {8'h12, 2'b00}) begin
      errors++;
      $display("FAIL ferr_recover_data: data=%h ferr=%b perr=%b expected 12 0 0",
               bus_a.rx_data, bus_a.rx_frame_err, bus_a.rx_parity_err);
    end
    bus_a.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_a.rx_ready = 1'b0;
  endtask

  task automatic test_overrun;
    int base;
    base = ovc;
    for (int i = 0; i < 16; i++) drive_bits(16'({1'b1, 8'(8'h10 + i), 1'b0}), 10, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus_a.rx_count !== 5'd16 || ovc - base != 0) begin
      errors++;
      $display("FAIL ovr_full16: count=%0d pulses=%0d expected 16 0", bus_a.rx_count, ovc - base);
    end
    drive_bits(16'({1'b1, 8'hEE, 1'b0}), 10, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus_a.rx_count !== 5'd16 || ovc - base != 1) begin
      errors++;
      $display("FAIL ovr_17th: count=%0d pulses=%0d expected 16 1", bus_a.rx_count, ovc - base);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus_a.rx_valid !== 1'b1 || bus_a.rx_data !== 8'(8'h10 + i)) begin
        errors++;
        $display("FAIL ovr_pop%0d: valid=%b data=%h expected 1 %h", i, bus_a.rx_valid, bus_a.rx_data, 8'(8'h10 + i));
      end
      bus_a.rx_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_a.rx_ready = 1'b0;
    end
    checks++;
    if (bus_a.rx_valid !== 1'b0 || bus_a.rx_count !== 5'd0) begin
      errors++;
      $display("FAIL ovr_drained: valid=%b count=%0d expected 0 0", bus_a.rx_valid, bus_a.rx_count);
    end
  endtask

  task automatic test_glitch;
    rxd_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rxd_a = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if (bus_a.rx_valid !== 1'b0 || bus_a.rx_count !== 5'd0) begin
      errors++;
      $display("FAIL glitch_push: valid=%b count=%0d expected 0 0", bus_a.rx_valid, bus_a.rx_count);
    end
  endtask

  task automatic test_reset_mid;
    int lows;
    drive_bits(16'({1'b1, 8'h77, 1'b0}), 10, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    bus_a.tx_data = 8'h00;
    bus_a.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_a.tx_data = 8'h01;
    @(posedge clk);
    #1;
    bus_a.tx_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if ({tx_a, bus_a.tx_count, bus_a.rx_valid} !== {1'b0, 5'd1, 1'b1}) begin
      errors++;
      $display("FAIL midframe_pre: tx=%b tx_count=%0d rx_valid=%b expected 0 1 1", tx_a, bus_a.tx_count, bus_a.rx_valid);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_a, bus_a.tx_count, bus_a.rx_valid, bus_a.rx_count, bus_a.tx_ready} !== {1'b1, 5'd0, 1'b0, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL midframe_reset: tx=%b tx_count=%0d rx_valid=%b rx_count=%0d tx_ready=%b expected 1 0 0 0 1",
               tx_a, bus_a.tx_count, bus_a.rx_valid, bus_a.rx_count, bus_a.tx_ready);
    end
    #1;
    rst = 1'b0;
    lows = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (tx_a !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0 || bus_a.rx_count !== 5'd0) begin
      errors++;
      $display("FAIL midframe_after: tx low %0d cycles, rx_count=%0d expected 0 0", lows, bus_a.rx_count);
    end
  endtask

  initial begin
    bus_a.tx_data = 8'h00;
    bus_a.tx_valid = 1'b0;
    bus_a.rx_ready = 1'b0;
    bus_b.tx_data = 8'h00;
    bus_b.tx_valid = 1'b0;
    bus_b.rx_ready = 1'b0;
    test_reset();
    test_tx_frame();
    test_loopback();
    test_parity();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
